spiflash_emu: RTL and testbench
===============================

# spiflash_emu

Synthesizable, parametrised SPI flash responder for the management SoC simulation and FPGA-prototype environment. It replaces the behavioural flash model with a block clocked by `sys_clk` that oversamples the SPI pins. It serves single (0x03), fast (0x0B) and optional dual-output (0x3B) reads from an internal byte array. The array is preloaded over a simple write port before the CPU boots.

## Interface
- `ADDR_BYTES`, 3: address bytes per command (3 or 4).
- `MEM_AW`, 10: byte-array depth is 2^MEM_AW.
- `DUMMY_CYCLES`, 8: SPI clocks of dummy for 0x0B and 0x3B (1..15).
- `DUAL_EN`, 1: 1 enables 0x3B; 0 treats 0x3B as unknown.

- `sys_clk`  in  1  system clock; must run at least 8x `spiflash_clk`.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `spiflash_cs_n`  in  1  chip select, active low.
- `spiflash_clk`  in  1  SPI clock, mode 0.
- `io0_i`  in  1  MOSI.
- `io0_o` / `io0_oe`  out  1/1  io0 drive (dual data only).
- `io1_o` / `io1_oe`  out  1/1  MISO drive.
- `load_we`  in  1  array write strobe.
- `load_addr`  in  MEM_AW  array write address.
- `load_data`  in  8  array write data.
- `busy`  out  1  high while CS is low (synchronized).
- `cmd_err`  out  1  one-cycle pulse on an unknown opcode.
- `load_err`  out  1  one-cycle pulse when `load_we` is dropped.

## Operation
- `spiflash_cs_n`, `spiflash_clk` and `io0_i` each pass through 2-flop synchronizers. The SPI rising and falling edges are detected from the synchronized clock (current vs previous).
- The FSM has six states: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
- A synchronized CS rise forces IDLE from any state. It also clears both `_oe` outputs and the bit counters.
- IDLE → CMD on synchronized CS fall.
- In CMD, ADDR and DUMMY, `io0_i` is sampled MSB-first on each SPI rising edge.
- CMD (8 bits) decodes the opcode:
  - 0x03: go to ADDR, then DATA with no dummy.
  - 0x0B: go to ADDR, then DUMMY, then single-mode DATA.
  - 0x3B with DUAL_EN=1: go to ADDR, then DUMMY, then dual-mode DATA.
  - 0x66, 0x99, 0xAB: accepted silently; go to IGNORE.
  - Any other opcode, including 0x3B with DUAL_EN=0: `cmd_err` pulses and the FSM goes to IGNORE.
- ADDR shifts 8×ADDR_BYTES bits. Only the low MEM_AW bits are kept; upper bits are ignored.
- DUMMY counts DUMMY_CYCLES rising edges.
- DATA, single mode:
  - `io1_oe`=1.
  - `io1_o` updates on each SPI falling edge, MSB first, 8 edges per byte.
- DATA, dual mode:
  - `io0_oe`=`io1_oe`=1.
  - Each falling edge drives `io1_o`=bit[2k+1] and `io0_o`=bit[2k], high pair first, 4 edges per byte.
- The address increments after each byte and wraps from 2^MEM_AW−1 to 0. DATA continues until CS rises.
- Prefetch: the next byte is read from the array in the `sys_clk` cycle after the current byte's first bit is driven.
- IGNORE drives nothing and ignores SPI edges until CS rises.
- Load port:
  - With `busy`=0, `load_we` writes `load_data` to `load_addr` on the same edge.
  - With `busy`=1 the write is dropped and `load_err` pulses.

## Timing
- All outputs reset to 0. FSM resets to IDLE and the address register to 0. Array contents are not reset.
- The bit at the first falling edge after the last address or dummy bit is the first data bit (mode 0).
- Pin-to-output latency:
  - SPI falling edge to `io1_o` change: 3 `sys_clk` (2 sync + 1 register).
  - With a 1:8 ratio this leaves ≥1 cycle of margin before the next rising edge.
- CS rise to `_oe`=0: 3 `sys_clk`.
- `busy` follows synchronized CS, 2 `sys_clk` after the pin.
- `cmd_err` asserts 1 `sys_clk` after the 8th command rising edge is detected.
- CS rise that coincides with an SPI edge: the CS rise wins and the edge is discarded.
- CS rise mid-byte: the partial byte is discarded and the next transaction restarts in CMD.
- `sys_rst_n` low mid-transfer: outputs go to 0 immediately (asynchronous). After release, the FSM waits in IDLE for the next CS fall, even if CS is already low.

## Test plan
- **Single read:** load 0x000–0x003 = A5, 5A, C3, 3C; `sys_clk` 10 MHz, SPI 1.25 MHz. Send 0x03 with address 0x000001 and clock 24 bits → MISO returns 5A, C3, 3C; `io0_oe` stays 0.
- **Fast read with wrap:** load 0x3FF=77 and 0x000=A5. Send 0x0B with address 0x0003FF and 8 dummy clocks → MISO returns 77 then A5.
- **Dual read:** DUAL_EN=1, 0x3B at address 0x000000 → pairs (io1,io0) = 10,10,01,01 for A5, then 01,01,10,10 for 5A. With DUAL_EN=0, the same opcode → `cmd_err` for 1 cycle and `_oe` stays 0 until CS rises.
- **Unknown opcode:** send 0x9F → `cmd_err` pulses once, both `_oe` stay 0, and the next 0x03 transaction reads correctly.
- **Abort:** raise CS after 3 data bits → `io1_oe`=0 within 3 cycles. The next 0x03 at address 0x000000 returns A5.
- **Load and reset during a transfer:** `load_we` with `busy`=1 → `load_err` pulses and the array is unchanged. `sys_rst_n` pulse mid-DATA → all outputs 0, then IDLE until a fresh CS fall.

Source files
------------

// File: rtl/spiflash_emu.sv
// spiflash_emu: SPI flash read responder clocked by sys_clk, oversampling the SPI pins.
// Serves 0x03 / 0x0B / 0x3B reads from an internal byte array preloaded over a write port.
module spiflash_emu #(
    parameter int ADDR_BYTES   = 3,
    parameter int MEM_AW       = 10,
    parameter int DUMMY_CYCLES = 8,
    parameter int DUAL_EN      = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              spiflash_cs_n,
    input  logic              spiflash_clk,
    input  logic              io0_i,
    output logic              io0_o,
    output logic              io0_oe,
    output logic              io1_o,
    output logic              io1_oe,
    input  logic              load_we,
    input  logic [MEM_AW-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy,
    output logic              cmd_err,
    output logic              load_err
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    localparam logic [5:0] ADDR_LAST  = 6'(8 * ADDR_BYTES - 1);
    localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_CYCLES - 1);

    logic [7:0]        r_mem [0:(2**MEM_AW)-1];
    logic              r_cs_meta, r_cs_act, r_cs_prev;
    logic              r_sck_meta, r_sck, r_sck_prev;
    logic              r_mosi_meta, r_mosi;
    logic [2:0]        r_vld;
    state_t            r_state, w_state_next;
    logic [6:0]        r_shift;
    logic [5:0]        r_bitcnt;
    logic [2:0]        r_dcnt;
    logic [MEM_AW-1:0] r_addr;
    logic [7:0]        r_pref, r_byte;
    logic              r_fetch, r_fast, r_dual;
    logic              r_io0_o, r_io0_oe, r_io1_o, r_io1_oe, r_cmd_err, r_load_err;
    logic              w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall, w_shift_phase;
    logic [7:0]        w_cmd_byte, w_out_byte;
    logic              w_cmd_err, w_cmd_fast, w_cmd_dual, w_enter_data;

    // r_cs_act is the synchronized, active-high chip select. A CS fall only counts
    // once r_cs_prev holds a genuinely sampled value (r_vld[2]), so a CS that is
    // already low when reset releases does not start a transaction.
    assign w_cs_rise     = ~r_cs_act & r_cs_prev;
    assign w_cs_fall     = r_vld[2] & r_cs_act & ~r_cs_prev;
    assign w_sck_rise    = r_sck & ~r_sck_prev;
    assign w_sck_fall    = ~r_sck & r_sck_prev;
    assign w_shift_phase = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DUMMY);
    assign w_cmd_byte    = {r_shift, r_mosi};
    // The first bit of each byte comes straight from the prefetch register.
    assign w_out_byte    = (r_dcnt == 3'd0) ? r_pref : r_byte;

    assign io0_o    = r_io0_o;
    assign io0_oe   = r_io0_oe;
    assign io1_o    = r_io1_o;
    assign io1_oe   = r_io1_oe;
    assign busy     = r_cs_act;
    assign cmd_err  = r_cmd_err;
    assign load_err = r_load_err;

    // Two-flop synchronizers for the SPI pins plus one-cycle history for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cs_meta   <= 1'b0;
            r_cs_act    <= 1'b0;
            r_cs_prev   <= 1'b0;
            r_sck_meta  <= 1'b0;
            r_sck       <= 1'b0;
            r_sck_prev  <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi      <= 1'b0;
            r_vld       <= 3'd0;
        end else begin
            r_cs_meta   <= ~spiflash_cs_n;
            r_cs_act    <= r_cs_meta;
            r_cs_prev   <= r_cs_act;
            r_sck_meta  <= spiflash_clk;
            r_sck       <= r_sck_meta;
            r_sck_prev  <= r_sck;
            r_mosi_meta <= io0_i;
            r_mosi      <= r_mosi_meta;
            r_vld       <= {r_vld[1:0], 1'b1};
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and opcode decode; a CS rise overrides any SPI edge in the same cycle
    always_comb begin
        w_state_next = r_state;
        w_cmd_err    = 1'b0;
        w_cmd_fast   = 1'b0;
        w_cmd_dual   = 1'b0;
        w_enter_data = 1'b0;
        if (w_cs_rise) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) w_state_next = ST_CMD;
                    else           w_state_next = ST_IDLE;
                end
                ST_CMD: begin
                    if (w_sck_rise && (r_bitcnt == 6'd7)) begin
                        case (w_cmd_byte)
                            8'h03: w_state_next = ST_ADDR;
                            8'h0B: begin
                                w_state_next = ST_ADDR;
                                w_cmd_fast   = 1'b1;
                            end
                            8'h3B: begin
                                if (DUAL_EN != 0) begin
                                    w_state_next = ST_ADDR;
                                    w_cmd_fast   = 1'b1;
                                    w_cmd_dual   = 1'b1;
                                end else begin
                                    w_state_next = ST_IGNORE;
                                    w_cmd_err    = 1'b1;
                                end
                            end
                            8'h66, 8'h99, 8'hAB: w_state_next = ST_IGNORE;
                            default: begin
                                w_state_next = ST_IGNORE;
                                w_cmd_err    = 1'b1;
                            end
                        endcase
                    end else begin
                        w_state_next = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (w_sck_rise && (r_bitcnt == ADDR_LAST)) begin
                        if (r_fast) begin
                            w_state_next = ST_DUMMY;
                        end else begin
                            w_state_next = ST_DATA;
                            w_enter_data = 1'b1;
                        end
                    end else begin
                        w_state_next = ST_ADDR;
                    end
                end
                ST_DUMMY: begin
                    if (w_sck_rise && (r_bitcnt == DUMMY_LAST)) begin
                        w_state_next = ST_DATA;
                        w_enter_data = 1'b1;
                    end else begin
                        w_state_next = ST_DUMMY;
                    end
                end
                ST_DATA:   w_state_next = ST_DATA;
                ST_IGNORE: w_state_next = ST_IGNORE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath: command/address shifting, prefetch, output shifting and error pulses
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_shift    <= 7'd0;
            r_bitcnt   <= 6'd0;
            r_dcnt     <= 3'd0;
            r_addr     <= '0;
            r_pref     <= 8'd0;
            r_byte     <= 8'd0;
            r_fetch    <= 1'b0;
            r_fast     <= 1'b0;
            r_dual     <= 1'b0;
            r_io0_o    <= 1'b0;
            r_io0_oe   <= 1'b0;
            r_io1_o    <= 1'b0;
            r_io1_oe   <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_cmd_err  <= w_cmd_err;
            r_load_err <= load_we & r_cs_act;
            if (w_cs_rise) begin
                r_bitcnt <= 6'd0;
                r_dcnt   <= 3'd0;
                r_fetch  <= 1'b0;
                r_io0_o  <= 1'b0;
                r_io0_oe <= 1'b0;
                r_io1_o  <= 1'b0;
                r_io1_oe <= 1'b0;
            end else begin
                if (w_state_next != r_state) begin
                    r_bitcnt <= 6'd0;
                end else if (w_sck_rise && w_shift_phase) begin
                    r_bitcnt <= r_bitcnt + 6'd1;
                end
                if ((r_state == ST_CMD) && w_sck_rise) begin
                    r_shift <= w_cmd_byte[6:0];
                    r_fast  <= w_cmd_fast;
                    r_dual  <= w_cmd_dual;
                end
                // Only the low MEM_AW address bits survive the shift.
                if ((r_state == ST_ADDR) && w_sck_rise) begin
                    r_addr <= {r_addr[MEM_AW-2:0], r_mosi};
                end
                if (w_enter_data) begin
                    r_fetch  <= 1'b1;
                    r_dcnt   <= 3'd0;
                    r_io1_oe <= 1'b1;
                    r_io0_oe <= r_dual;
                end
                if (r_fetch) begin
                    r_pref  <= r_mem[r_addr];
                    r_addr  <= r_addr + MEM_AW'(1);
                    r_fetch <= 1'b0;
                end
                if ((r_state == ST_DATA) && w_sck_fall) begin
                    r_io1_o <= w_out_byte[7];
                    if (r_dual) begin
                        r_io0_o <= w_out_byte[6];
                        r_byte  <= {w_out_byte[5:0], 2'b00};
                        r_dcnt  <= (r_dcnt == 3'd3) ? 3'd0 : (r_dcnt + 3'd1);
                    end else begin
                        r_byte  <= {w_out_byte[6:0], 1'b0};
                        r_dcnt  <= r_dcnt + 3'd1;
                    end
                    // The byte just started has left r_pref; fetch the following one.
                    if (r_dcnt == 3'd0) r_fetch <= 1'b1;
                end
            end
        end
    end

    // Preload port; writes are dropped while a transaction is active
    always_ff @(posedge sys_clk) begin
        if (load_we && !r_cs_act) begin
            r_mem[load_addr] <= load_data;
        end
    end
endmodule

// File: tb/tb_spiflash_emu.sv
// tb_spiflash_emu: scoreboard bench for spiflash_emu (sys_clk 10 MHz, SPI 1.25 MHz, mode 0).
`timescale 1ns/1ps
module tb_spiflash_emu;
    localparam int AW   = 10;
    localparam int HALF = 400;

    logic          sys_clk, sys_rst_n, cs_n, sck, mosi;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic          io0_o, io0_oe, io1_o, io1_oe, busy, cmd_err, load_err;
    logic          nd_io0_o, nd_io0_oe, nd_io1_o, nd_io1_oe, nd_busy, nd_cmd_err, nd_load_err;

    int            n_vec = 0;
    int            n_miscmp = 0;
    logic [7:0]    exp_q[$];
    int            io0_oe_cyc = 0, io1_oe_cyc = 0, cmd_err_cyc = 0, load_err_cyc = 0;
    int            nd_oe_cyc = 0, nd_cmd_err_cyc = 0;
    int            b_io0, b_io1, b_err, b_lerr, b_nd_oe, b_nd_err;

    spiflash_emu #(.ADDR_BYTES(3), .MEM_AW(AW), .DUMMY_CYCLES(8), .DUAL_EN(1)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .spiflash_cs_n(cs_n), .spiflash_clk(sck),
        .io0_i(mosi), .io0_o(io0_o), .io0_oe(io0_oe), .io1_o(io1_o), .io1_oe(io1_oe),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .busy(busy), .cmd_err(cmd_err), .load_err(load_err)
    );

    spiflash_emu #(.ADDR_BYTES(3), .MEM_AW(AW), .DUMMY_CYCLES(8), .DUAL_EN(0)) dut_nd (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .spiflash_cs_n(cs_n), .spiflash_clk(sck),
        .io0_i(mosi), .io0_o(nd_io0_o), .io0_oe(nd_io0_oe), .io1_o(nd_io1_o), .io1_oe(nd_io1_oe),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .busy(nd_busy), .cmd_err(nd_cmd_err), .load_err(nd_load_err)
    );

    initial begin
        sys_clk = 1'b0;
        forever #50 sys_clk = ~sys_clk;
    end

    // Per-cycle activity counters, sampled on the inactive edge
    always @(negedge sys_clk) begin
        if (io0_oe)                io0_oe_cyc++;
        if (io1_oe)                io1_oe_cyc++;
        if (cmd_err)               cmd_err_cyc++;
        if (load_err)              load_err_cyc++;
        if (nd_io0_oe | nd_io1_oe) nd_oe_cyc++;
        if (nd_cmd_err)            nd_cmd_err_cyc++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_io0 = io0_oe_cyc; b_io1 = io1_oe_cyc; b_err = cmd_err_cyc; b_lerr = load_err_cyc;
        b_nd_oe = nd_oe_cyc; b_nd_err = nd_cmd_err_cyc;
    endtask

    task automatic spi_bit(input logic b, output logic s1, output logic s0);
        mosi = b;
        #(HALF);
        s1 = io1_o;
        s0 = io0_o;
        sck = 1'b1;
        #(HALF);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        logic d1, d0;
        for (int i = 7; i >= 0; i--) spi_bit(v[i], d1, d0);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        #200;
    endtask

    task automatic cs_end();
        #200;
        cs_n = 1'b1;
        #800;
    endtask

    task automatic start_read(input logic [7:0] op, input logic [23:0] addr, input int ndummy);
        logic d1, d0;
        cs_begin();
        spi_byte(op);
        spi_byte(addr[23:16]);
        spi_byte(addr[15:8]);
        spi_byte(addr[7:0]);
        for (int i = 0; i < ndummy; i++) spi_bit(1'b0, d1, d0);
    endtask

    // Collect bytes from the pins and compare against the scoreboard head
    task automatic read_check(input int nbytes, input logic dual, input string tag);
        logic [7:0] got;
        logic       s1, s0;
        for (int b = 0; b < nbytes; b++) begin
            got = 8'h00;
            if (dual) begin
                for (int k = 0; k < 4; k++) begin
                    spi_bit(1'b0, s1, s0);
                    got = {got[5:0], s1, s0};
                end
            end else begin
                for (int k = 0; k < 8; k++) begin
                    spi_bit(1'b0, s1, s0);
                    got = {got[6:0], s1};
                end
            end
            if (exp_q.size() == 0) check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
            else                   check_eq(tag, {24'd0, got}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic load_byte(input logic [AW-1:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_we   = 1'b1;
        #100;
        load_we   = 1'b0;
    endtask

    initial begin
        logic d1, d0;
        sys_rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = 8'h00;
        #200;
        check_eq("reset_outs", {25'd0, io0_o, io0_oe, io1_o, io1_oe, busy, cmd_err, load_err}, 32'd0);
        check_eq("reset_nd_outs", {25'd0, nd_io0_o, nd_io0_oe, nd_io1_o, nd_io1_oe, nd_busy,
                                   nd_cmd_err, nd_load_err}, 32'd0);
        #20;
        sys_rst_n = 1'b1;
        #300;
        load_byte(10'h000, 8'hA5);
        load_byte(10'h001, 8'h5A);
        load_byte(10'h002, 8'hC3);
        load_byte(10'h003, 8'h3C);
        load_byte(10'h3FF, 8'h77);
        #200;

        // Single read from address 1
        snap();
        exp_q.push_back(8'h5A); exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
        start_read(8'h03, 24'h000001, 0);
        read_check(3, 1'b0, "single");
        check_eq("single_io1_oe_on", {31'd0, io1_oe}, 32'd1);
        check_eq("single_io0_oe_off", 32'(io0_oe_cyc - b_io0), 32'd0);
        cs_end();
        check_eq("single_io1_oe_off", {31'd0, io1_oe}, 32'd0);

        // Fast read across the top of the array
        exp_q.push_back(8'h77); exp_q.push_back(8'hA5);
        start_read(8'h0B, 24'h0003FF, 8);
        read_check(2, 1'b0, "fast_wrap");
        cs_end();

        // Dual read; the DUAL_EN=0 instance must flag the opcode and stay silent
        snap();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        start_read(8'h3B, 24'h000000, 8);
        read_check(2, 1'b1, "dual");
        check_eq("dual_io0_oe_on", {31'd0, io0_oe}, 32'd1);
        check_eq("dual_cmd_err", 32'(cmd_err_cyc - b_err), 32'd0);
        check_eq("nodual_cmd_err", 32'(nd_cmd_err_cyc - b_nd_err), 32'd1);
        check_eq("nodual_oe", 32'(nd_oe_cyc - b_nd_oe), 32'd0);
        cs_end();

        // Unknown opcode, then a normal read
        snap();
        cs_begin();
        spi_byte(8'h9F);
        spi_byte(8'h00);
        cs_end();
        check_eq("unk_cmd_err", 32'(cmd_err_cyc - b_err), 32'd1);
        check_eq("unk_oe", 32'((io0_oe_cyc - b_io0) + (io1_oe_cyc - b_io1)), 32'd0);
        exp_q.push_back(8'hC3);
        start_read(8'h03, 24'h000002, 0);
        read_check(1, 1'b0, "after_unk");
        cs_end();

        // Abort after three data bits
        start_read(8'h03, 24'h000000, 0);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, d1, d0);
        check_eq("abort_oe_before", {31'd0, io1_oe}, 32'd1);
        cs_n = 1'b1;
        #300;
        check_eq("abort_oe_off", {31'd0, io1_oe}, 32'd0);
        #500;
        exp_q.push_back(8'hA5);
        start_read(8'h03, 24'h000000, 0);
        read_check(1, 1'b0, "after_abort");
        cs_end();

        // Load while busy is dropped
        snap();
        cs_begin();
        check_eq("busy_on", {31'd0, busy}, 32'd1);
        load_byte(10'h000, 8'h00);
        #100;
        check_eq("load_err", 32'(load_err_cyc - b_lerr), 32'd1);
        cs_end();
        check_eq("busy_off", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'hA5);
        start_read(8'h03, 24'h000000, 0);
        read_check(1, 1'b0, "after_drop");
        cs_end();

        // Reset in the middle of DATA, CS held low across the release
        start_read(8'h03, 24'h000000, 0);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, d1, d0);
        sys_rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", {25'd0, io0_o, io0_oe, io1_o, io1_oe, busy, cmd_err, load_err}, 32'd0);
        #199;
        sys_rst_n = 1'b1;
        #300;
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        snap();
        spi_byte(8'h03);
        spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00);
        spi_byte(8'h00);
        check_eq("rst_idle_oe", 32'(io1_oe_cyc - b_io1), 32'd0);
        check_eq("rst_idle_err", 32'(cmd_err_cyc - b_err), 32'd0);
        cs_end();
        exp_q.push_back(8'h5A);
        start_read(8'h03, 24'h000001, 0);
        read_check(1, 1'b0, "after_rst");
        cs_end();

        check_eq("sb_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
